// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement, snoop write-back/invalidate and a full-array flush on halt.
module dcache_nway #(
    parameter int WAYS     = 2,
    parameter int SETS     = 8,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic        cctrans,
    output logic [2:0]  dbg_state_o
);
    localparam int OB  = $clog2(BLKWORDS);
    localparam int OW  = (OB > 0) ? OB : 1;
    localparam int IB  = $clog2(SETS);
    localparam int WB_ = $clog2(WAYS);
    localparam int AW  = (WB_ > 0) ? WB_ : 1;
    localparam int TW  = 30 - OB - IB;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB      = 3'd1,
        S_FILL    = 3'd2,
        S_SNOOPWB = 3'd3,
        S_FLUSH   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    logic          valid_q [SETS][WAYS];
    logic          dirty_q [SETS][WAYS];
    logic [TW-1:0] tag_q   [SETS][WAYS];
    logic [AW-1:0] age_q   [SETS][WAYS];
    logic [31:0]   data_q  [SETS][WAYS][BLKWORDS];

    state_t        state_q;
    logic [OW-1:0] wc_q;
    logic [AW-1:0] vway_q, sway_q, fway_q;
    logic [IB-1:0] midx_q, sidx_q, fset_q;
    logic [TW-1:0] mtag_q;
    logic          sinv_q, flushed_q;

    logic [TW-1:0] req_tag, sn_tag;
    logic [IB-1:0] req_idx, sn_idx;
    logic [OW-1:0] req_off;
    logic          hit_any, sn_hit, last_wc, req, flush_dirty, flush_adv, lru_en;
    logic [AW-1:0] hit_way, sn_way, vic, lru_way, lru_old;
    logic [IB-1:0] lru_set;
    logic [AW-1:0] age_new [WAYS];
    logic          unused_snoop_bits;

    function automatic logic [31:0] blk_addr(input logic [TW-1:0] t, input logic [IB-1:0] i,
                                             input logic [OW-1:0] w);
        blk_addr = (32'(t) << (2 + OB + IB)) | (32'(i) << (2 + OB)) |
                   ((32'(w) & 32'(BLKWORDS - 1)) << 2);
    endfunction

    assign req_tag = dmemaddr[31 -: TW];
    assign req_idx = dmemaddr[2+OB +: IB];
    assign req_off = OW'((dmemaddr >> 2) & 32'(BLKWORDS - 1));
    assign sn_tag  = ccsnoopaddr[31 -: TW];
    assign sn_idx  = ccsnoopaddr[2+OB +: IB];
    assign unused_snoop_bits = ^ccsnoopaddr;

    assign req         = dmemREN || dmemWEN;
    assign last_wc     = (wc_q == OW'(BLKWORDS - 1));
    assign flush_dirty = valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q];
    assign flush_adv   = !flush_dirty || (!dwait && last_wc);

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        sn_hit  = 1'b0;
        sn_way  = '0;
        vic     = '0;
        for (int j = 0; j < WAYS; j++) begin
            if (valid_q[req_idx][j] && tag_q[req_idx][j] == req_tag) begin
                hit_any = 1'b1;
                hit_way = AW'(j);
            end
            if (valid_q[sn_idx][j] && tag_q[sn_idx][j] == sn_tag) begin
                sn_hit = 1'b1;
                sn_way = AW'(j);
            end
            if (age_q[req_idx][j] == AW'(WAYS - 1))
                vic = AW'(j);
        end
        // An invalid way always beats the oldest one; scan downward so the lowest wins.
        for (int j = WAYS - 1; j >= 0; j--) begin
            if (!valid_q[req_idx][j])
                vic = AW'(j);
        end
    end

    always_comb begin
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = dmemaddr;
        dstore   = '0;
        dhit     = 1'b0;
        dmemload = '0;
        case (state_q)
            S_IDLE: begin
                dhit = !ccwait && !halt && req && hit_any;
                if (dhit && dmemREN)
                    dmemload = data_q[req_idx][hit_way][req_off];
            end
            S_WB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(tag_q[midx_q][vway_q], midx_q, wc_q);
                dstore = data_q[midx_q][vway_q][wc_q];
            end
            S_FILL: begin
                dREN  = 1'b1;
                daddr = blk_addr(mtag_q, midx_q, wc_q);
            end
            S_SNOOPWB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(tag_q[sidx_q][sway_q], sidx_q, wc_q);
                dstore = data_q[sidx_q][sway_q][wc_q];
            end
            S_FLUSH: begin
                if (flush_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = blk_addr(tag_q[fset_q][fway_q], fset_q, wc_q);
                    dstore = data_q[fset_q][fway_q][wc_q];
                end
            end
            default: ;
        endcase
    end

    // LRU: accessed way becomes youngest, every way younger than it ages by one.
    always_comb begin
        lru_set = (state_q == S_IDLE) ? req_idx : midx_q;
        lru_way = (state_q == S_IDLE) ? hit_way : vway_q;
        lru_en  = dhit || (state_q == S_FILL && !dwait && last_wc);
        lru_old = age_q[lru_set][lru_way];
        for (int j = 0; j < WAYS; j++) begin
            age_new[j] = age_q[lru_set][j];
            if (AW'(j) == lru_way)
                age_new[j] = '0;
            else if (age_q[lru_set][j] < lru_old)
                age_new[j] = age_q[lru_set][j] + AW'(1);
        end
    end

    assign cctrans     = (state_q == S_SNOOPWB);
    assign flushed     = flushed_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            wc_q      <= '0;
            vway_q    <= '0;
            sway_q    <= '0;
            fway_q    <= '0;
            midx_q    <= '0;
            sidx_q    <= '0;
            fset_q    <= '0;
            mtag_q    <= '0;
            sinv_q    <= 1'b0;
            flushed_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= AW'(w);
                    for (int k = 0; k < BLKWORDS; k++)
                        data_q[s][w][k] <= '0;
                end
            end
        end else begin
            if (lru_en) begin
                for (int j = 0; j < WAYS; j++)
                    age_q[lru_set][j] <= age_new[j];
            end
            case (state_q)
                S_IDLE: begin
                    if (ccwait) begin
                        if (sn_hit && dirty_q[sn_idx][sn_way]) begin
                            state_q <= S_SNOOPWB;
                            sidx_q  <= sn_idx;
                            sway_q  <= sn_way;
                            sinv_q  <= ccinv;
                            wc_q    <= '0;
                        end else if (sn_hit && ccinv) begin
                            valid_q[sn_idx][sn_way] <= 1'b0;
                        end
                    end else if (halt) begin
                        state_q <= S_FLUSH;
                        fset_q  <= '0;
                        fway_q  <= '0;
                        wc_q    <= '0;
                    end else if (req) begin
                        if (hit_any) begin
                            if (dmemWEN) begin
                                data_q[req_idx][hit_way][req_off] <= dmemstore;
                                dirty_q[req_idx][hit_way]         <= 1'b1;
                            end
                        end else begin
                            midx_q  <= req_idx;
                            mtag_q  <= req_tag;
                            vway_q  <= vic;
                            wc_q    <= '0;
                            state_q <= (valid_q[req_idx][vic] && dirty_q[req_idx][vic]) ? S_WB : S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (!dwait) begin
                        if (last_wc) begin
                            dirty_q[midx_q][vway_q] <= 1'b0;
                            wc_q    <= '0;
                            state_q <= S_FILL;
                        end else begin
                            wc_q <= wc_q + OW'(1);
                        end
                    end
                end
                S_FILL: begin
                    if (!dwait) begin
                        data_q[midx_q][vway_q][wc_q] <= dload;
                        if (last_wc) begin
                            valid_q[midx_q][vway_q] <= 1'b1;
                            dirty_q[midx_q][vway_q] <= 1'b0;
                            tag_q[midx_q][vway_q]   <= mtag_q;
                            wc_q    <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            valid_q[midx_q][vway_q] <= 1'b0;
                            wc_q <= wc_q + OW'(1);
                        end
                    end
                end
                S_SNOOPWB: begin
                    if (!dwait) begin
                        if (last_wc) begin
                            dirty_q[sidx_q][sway_q] <= 1'b0;
                            if (sinv_q)
                                valid_q[sidx_q][sway_q] <= 1'b0;
                            wc_q    <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            wc_q <= wc_q + OW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_adv) begin
                        if (flush_dirty)
                            dirty_q[fset_q][fway_q] <= 1'b0;
                        wc_q <= '0;
                        if (fway_q == AW'(WAYS - 1)) begin
                            fway_q <= '0;
                            if (fset_q == IB'(SETS - 1)) begin
                                state_q   <= S_DONE;
                                flushed_q <= 1'b1;
                            end else begin
                                fset_q <= fset_q + IB'(1);
                            end
                        end else begin
                            fway_q <= fway_q + AW'(1);
                        end
                    end else if (!dwait) begin
                        wc_q <= wc_q + OW'(1);
                    end
                end
                S_DONE: flushed_q <= 1'b1;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway: a 2-way/2-word instance for fills, write-backs,
// snoops, flush and reset, plus a 4-way/4-word instance for LRU victim choice.
module tb_dcache_nway;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ren = 1'b0, wen = 1'b0, sel4 = 1'b0;
    logic [31:0] addr = 32'h0000_1234, store = '0, snaddr = '0;
    logic        halt = 1'b0, ccwait = 1'b0, ccinv = 1'b0;
    logic        mem_slow = 1'b0, dwait_tog = 1'b0, dwait;

    logic [31:0] dmemload0, daddr0, dstore0, dload0;
    logic        dhit0, flushed0, dREN0, dWEN0, cctrans0;
    logic [2:0]  dbg0;
    logic [31:0] dmemload4, daddr4, dstore4, dload4;
    logic        dhit4, flushed4, dREN4, dWEN4, cctrans4;
    logic [2:0]  dbg4;

    int checks = 0, errors = 0;
    logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) dwait_tog <= ~dwait_tog;
    assign dwait  = mem_slow & dwait_tog;
    assign dload0 = daddr0 + 32'h1000_0000;
    assign dload4 = daddr4 + 32'h1000_0000;

    dcache_nway #(.WAYS(2), .SETS(8), .BLKWORDS(2)) dut (
        .CLK(CLK), .RST(RST), .dmemREN(ren & ~sel4), .dmemWEN(wen & ~sel4),
        .dmemaddr(addr), .dmemstore(store), .dmemload(dmemload0), .dhit(dhit0),
        .halt(halt), .flushed(flushed0), .dREN(dREN0), .dWEN(dWEN0), .daddr(daddr0),
        .dstore(dstore0), .dload(dload0), .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(snaddr), .cctrans(cctrans0), .dbg_state_o(dbg0));

    dcache_nway #(.WAYS(4), .SETS(8), .BLKWORDS(4)) dut4 (
        .CLK(CLK), .RST(RST), .dmemREN(ren & sel4), .dmemWEN(wen & sel4),
        .dmemaddr(addr), .dmemstore(store), .dmemload(dmemload4), .dhit(dhit4),
        .halt(1'b0), .flushed(flushed4), .dREN(dREN4), .dWEN(dWEN4), .daddr(daddr4),
        .dstore(dstore4), .dload(dload4), .dwait(dwait), .ccwait(1'b0), .ccinv(1'b0),
        .ccsnoopaddr(32'h0), .cctrans(cctrans4), .dbg_state_o(dbg4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $display("FAIL %s: observed timeout expected DUT event", tag);
    endtask

    // Memory-side monitor for the 2-way instance: logs beats, checks hold while stalled.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0, pend_data = '0;
    always @(negedge CLK) begin
        if (RST) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("hold_daddr", daddr0, pend_addr);
                if (dWEN0) chk("hold_dstore", dstore0, pend_data);
            end
            if ((dREN0 || dWEN0) && !dwait) begin
                if (dREN0) rd_log.push_back(daddr0);
                if (dWEN0) begin
                    wr_addr_log.push_back(daddr0);
                    wr_data_log.push_back(dstore0);
                end
            end
            pend      = (dREN0 || dWEN0) && dwait;
            pend_addr = daddr0;
            pend_data = dstore0;
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        exp_q.delete();
    endtask

    // kind: 0 = read addresses, 1 = write addresses, 2 = write data
    task automatic check_log(input string tag, input int kind);
        logic [31:0] got[$];
        if (kind == 0) got = rd_log;
        else if (kind == 1) got = wr_addr_log;
        else got = wr_data_log;
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(tag, got[i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic access(input logic s4, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        logic done;
        @(posedge CLK); #1;
        sel4 = s4; ren = !wr; wen = wr; addr = a; store = wd;
        cyc = 0; rd = '0; done = 1'b0;
        while (!done && cyc <= 200) begin
            @(negedge CLK);
            if (s4 ? dhit4 : dhit0) begin
                rd = s4 ? dmemload4 : dmemload0;
                done = 1'b1;
            end else begin
                cyc++;
            end
        end
        if (!done) timeout_fail("access_dhit");
        @(posedge CLK); #1;
        ren = 1'b0; wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int cyc, n;

        // Reset values
        #12;
        chk("rst_dREN", {31'b0, dREN0}, 32'd0);
        chk("rst_dWEN", {31'b0, dWEN0}, 32'd0);
        chk("rst_dhit", {31'b0, dhit0}, 32'd0);
        chk("rst_cctrans", {31'b0, cctrans0}, 32'd0);
        chk("rst_flushed", {31'b0, flushed0}, 32'd0);
        chk("rst_dstore", dstore0, 32'd0);
        chk("rst_dmemload", dmemload0, 32'd0);
        chk("rst_daddr", daddr0, 32'h0000_1234);
        chk("rst_state", {29'b0, dbg0}, 32'd0);
        chk("rst4_outs", {25'b0, dREN4, dWEN4, dhit4, cctrans4, flushed4, dbg4}, 32'd0);
        chk("rst4_data", dstore4 | dmemload4, 32'd0);
        @(negedge CLK); RST = 1'b0;

        // 4-way LRU: fill tags 0..3 of set 0, touch tag0, tag4 must evict tag1
        access(1, 0, 32'h000, 0, rd, cyc); chk("lru_fill0_cyc", cyc, 5);
        access(1, 0, 32'h080, 0, rd, cyc);
        access(1, 0, 32'h100, 0, rd, cyc);
        access(1, 0, 32'h180, 0, rd, cyc); chk("lru_fill3_data", rd, 32'h1000_0180);
        access(1, 0, 32'h000, 0, rd, cyc); chk("lru_touch0_cyc", cyc, 0);
        access(1, 0, 32'h200, 0, rd, cyc); chk("lru_tag4_cyc", cyc, 5);
        chk("lru_tag4_data", rd, 32'h1000_0200);
        access(1, 0, 32'h000, 0, rd, cyc); chk("lru_tag0_kept", cyc, 0);
        access(1, 0, 32'h100, 0, rd, cyc); chk("lru_tag2_kept", cyc, 0);
        access(1, 0, 32'h180, 0, rd, cyc); chk("lru_tag3_kept", cyc, 0);
        access(1, 0, 32'h080, 0, rd, cyc); chk("lru_tag1_evicted", cyc, 5);

        // Cold read, then hits
        clear_logs();
        access(0, 0, 32'h100, 0, rd, cyc);
        chk("cold_cyc", cyc, 3);
        chk("cold_data", rd, 32'h1000_0100);
        exp_q = '{32'h100, 32'h104}; check_log("cold_fill_addr", 0);
        access(0, 0, 32'h100, 0, rd, cyc);
        chk("hit_cyc", cyc, 0); chk("hit_data", rd, 32'h1000_0100);
        access(0, 0, 32'h104, 0, rd, cyc);
        chk("hit_w1_cyc", cyc, 0); chk("hit_w1_data", rd, 32'h1000_0104);

        // Write-allocate with a stalling memory
        clear_logs();
        mem_slow = 1'b1;
        access(0, 1, 32'h200, 32'hDEAD_BEEF, rd, cyc);
        exp_q = '{32'h200, 32'h204}; check_log("wa_fill_addr", 0);
        mem_slow = 1'b0;

        // Conflict eviction of the dirty line
        access(0, 0, 32'h100, 0, rd, cyc); chk("touch100_cyc", cyc, 0);
        clear_logs();
        access(0, 0, 32'h400, 0, rd, cyc);
        chk("dirty_miss_cyc", cyc, 5);
        chk("dirty_miss_data", rd, 32'h1000_0400);
        exp_q = '{32'h200, 32'h204}; check_log("wb_addr", 1);
        exp_q = '{32'hDEAD_BEEF, 32'h1000_0204}; check_log("wb_data", 2);
        exp_q = '{32'h400, 32'h404}; check_log("wb_fill_addr", 0);

        // Snoop write-back with invalidate
        access(0, 1, 32'h300, 32'h1111_1111, rd, cyc); chk("snp_prep_cyc", cyc, 3);
        clear_logs();
        @(posedge CLK); #1;
        ccwait = 1'b1; ccinv = 1'b1; snaddr = 32'h300;
        @(negedge CLK);
        @(negedge CLK);
        chk("snp_cctrans", {31'b0, cctrans0}, 32'd1);
        n = 0;
        while (cctrans0 && n < 50) begin @(negedge CLK); n++; end
        if (cctrans0) timeout_fail("snp_done");
        chk("snp_state_idle", {29'b0, dbg0}, 32'd0);
        @(posedge CLK); #1;
        ccwait = 1'b0; ccinv = 1'b0;
        exp_q = '{32'h300, 32'h304}; check_log("snp_addr", 1);
        exp_q = '{32'h1111_1111, 32'h1000_0304}; check_log("snp_data", 2);
        access(0, 0, 32'h300, 0, rd, cyc); chk("snp_inv_miss_cyc", cyc, 3);

        // Flush with three dirty blocks
        access(0, 1, 32'h008, 32'hAAAA_0001, rd, cyc);
        access(0, 1, 32'h010, 32'hAAAA_0002, rd, cyc);
        access(0, 1, 32'h018, 32'hAAAA_0003, rd, cyc);
        clear_logs();
        @(posedge CLK); #1; halt = 1'b1;
        n = 0;
        while (!flushed0 && n < 200) begin @(negedge CLK); n++; end
        if (!flushed0) timeout_fail("flush_done");
        exp_q = '{32'h008, 32'h00C, 32'h010, 32'h014, 32'h018, 32'h01C};
        check_log("flush_addr", 1);
        exp_q = '{32'hAAAA_0001, 32'h1000_000C, 32'hAAAA_0002, 32'h1000_0014,
                  32'hAAAA_0003, 32'h1000_001C};
        check_log("flush_data", 2);
        clear_logs();
        @(posedge CLK); #1; halt = 1'b0;
        repeat (5) @(negedge CLK);
        chk("flushed_sticky", {31'b0, flushed0}, 32'd1);
        chk("done_state", {29'b0, dbg0}, 32'd5);
        chk("done_quiet", 32'(wr_addr_log.size() + rd_log.size()), 32'd0);

        // Reset leaves DONE, then reset again in the middle of a fill
        @(negedge CLK); RST = 1'b1; #1;
        chk("rst_clears_flushed", {31'b0, flushed0}, 32'd0);
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        sel4 = 1'b0; ren = 1'b1; addr = 32'h100;
        n = 0;
        while (!(dREN0 && daddr0 == 32'h104) && n < 50) begin @(negedge CLK); n++; end
        if (!(dREN0 && daddr0 == 32'h104)) timeout_fail("fill_word1");
        #1; RST = 1'b1; #1;
        chk("midrst_outs", {27'b0, dREN0, dWEN0, dhit0, cctrans0, flushed0}, 32'd0);
        chk("midrst_daddr", daddr0, 32'h100);
        chk("midrst_state", {29'b0, dbg0}, 32'd0);
        @(posedge CLK); #1; ren = 1'b0;
        @(negedge CLK); RST = 1'b0;
        access(0, 0, 32'h100, 0, rd, cyc);
        chk("post_rst_miss_cyc", cyc, 3);
        chk("post_rst_data", rd, 32'h1000_0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
